// File: rtl/jericalla_issue.sv
// Instruction issue unit for the 3-stage Jericalla datapath: program store, RAW scoreboard, bubble insertion.
// Optional feature macro JERICALLA_ISSUE_STATS_EN adds a saturating stall_count output.

module jericalla_issue #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned HAZ_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [16:0]       prog_data,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   output logic [16:0]       instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done
`ifdef JERICALLA_ISSUE_STATS_EN
   ,
   output logic [15:0]       stall_count
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int unsigned       DEPTH      = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W + 1)'(1);
   localparam logic [2:0]        DRAIN_LAST = 3'(HAZ_DEPTH);

   state_t            state;
   logic [16:0]       mem [DEPTH];
   logic [ADDR_W:0]   len;
   logic [2:0]        drain_cnt;
   logic              sb_wr [HAZ_DEPTH];
   logic [4:0]        sb_wa [HAZ_DEPTH];

   logic [16:0]       cand;
   logic              cand_wr;
   logic              hazard;
   logic              issue;
   logic              last_issue;
   logic              sb_shift;
   logic              sb_in_wr;
   logic [4:0]        sb_in_wa;
   logic              start_ok;

   always_ff @(posedge clk) begin
      if (prog_we && !busy) begin
         mem[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      cand       = mem[pc];
      cand_wr    = (cand[16:15] != 2'b11);
      hazard     = 1'b0;
      for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
         if (sb_wr[i] && ((sb_wa[i] == cand[9:5]) || (sb_wa[i] == cand[4:0]))) begin
            hazard = 1'b1;
         end
      end
      issue      = (state == RUN) && !hazard;
      last_issue = ({1'b0, pc} == (len - LEN_ONE));
      sb_shift   = (state == RUN) || (state == DRAIN);
      sb_in_wr   = issue && cand_wr;
      sb_in_wa   = sb_in_wr ? cand[14:10] : '0;
      start_ok   = (state == IDLE) && start;
   end

   // Entry 0 is the newest; one entry enters every RUN/DRAIN cycle, bubbles enter as {0,0}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
            sb_wr[i] <= 1'b0;
            sb_wa[i] <= '0;
         end
      end else if (start_ok) begin
         for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
            sb_wr[i] <= 1'b0;
            sb_wa[i] <= '0;
         end
      end else if (sb_shift) begin
         for (int unsigned i = HAZ_DEPTH - 1; i > 0; i--) begin
            sb_wr[i] <= sb_wr[i-1];
            sb_wa[i] <= sb_wa[i-1];
         end
         sb_wr[0] <= sb_in_wr;
         sb_wa[0] <= sb_in_wa;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         instr       <= '0;
         instr_valid <= 1'b0;
         pc          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         len         <= '0;
         drain_cnt   <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (prog_len != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                     pc    <= '0;
                     len   <= prog_len;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (hazard) begin
                  instr       <= '0;
                  instr_valid <= 1'b0;
               end else begin
                  instr       <= cand;
                  instr_valid <= 1'b1;
                  pc          <= pc + PC_ONE;
                  if (last_issue) begin
                     state     <= DRAIN;
                     drain_cnt <= '0;
                  end
               end
            end
            DRAIN: begin
               // HAZ_DEPTH bubbles, then the done cycle itself lands back in IDLE.
               instr       <= '0;
               instr_valid <= 1'b0;
               if (drain_cnt == DRAIN_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef JERICALLA_ISSUE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (start_ok) begin
         stall_count <= '0;
      end else if ((state == RUN) && hazard && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_jericalla_issue.sv
// Self-checking bench for jericalla_issue (ADDR_W=5, HAZ_DEPTH=2); expected issue words are queued at load time.
// Define JERICALLA_ISSUE_STATS_EN to also check stall_count.

module tb_jericalla_issue;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [16:0]   prog_data = '0;
   logic          start = 1'b0;
   logic [AW:0]   prog_len = '0;
   logic [16:0]   instr;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          busy;
   logic          done;
`ifdef JERICALLA_ISSUE_STATS_EN
   logic [15:0]   stall_count;
`endif

   jericalla_issue #(.ADDR_W(AW), .HAZ_DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .start      (start),
      .prog_len   (prog_len),
      .instr      (instr),
      .instr_valid(instr_valid),
      .pc         (pc),
      .busy       (busy),
      .done       (done)
`ifdef JERICALLA_ISSUE_STATS_EN
      ,
      .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [16:0]   prog_q[$];
   logic [16:0]   exp_q[$];
   logic [16:0]   obs_q[$];
   int            obs_cyc[$];
   int            ecyc[$];
   int            done_cyc;
   int            done_cnt;
   int            busy_seen;
   int            bubble_nz;
   logic [AW-1:0] pc_at_done;
`ifdef JERICALLA_ISSUE_STATS_EN
   logic [15:0]   stall_done;
   logic [15:0]   stall_c1;
`endif

   // Writes prog_q into the store from address 0 and queues the expected issue order.
   task automatic load_prog();
      exp_q.delete();
      for (int i = 0; i < prog_q.size(); i++) begin
         @(negedge clk);
         prog_we   = 1'b1;
         prog_addr = i[AW-1:0];
         prog_data = prog_q[i];
         exp_q.push_back(prog_q[i]);
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Pulses start and records issues/done for a fixed cycle budget; inj_cyc pokes start+prog_we while busy.
   task automatic run(input int len, input int inj_cyc, input int budget,
                      input logic we0, input logic [16:0] wd0);
      obs_q.delete();
      obs_cyc.delete();
      done_cyc  = -1;
      done_cnt  = 0;
      busy_seen = 0;
      bubble_nz = 0;
      @(negedge clk);
      start     = 1'b1;
      prog_len  = len[AW:0];
      prog_we   = we0;
      prog_addr = '0;
      prog_data = wd0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         start   = 1'b0;
         prog_we = 1'b0;
         if (instr_valid) begin
            obs_q.push_back(instr);
            obs_cyc.push_back(cyc);
         end else if (instr !== 17'd0) begin
            bubble_nz++;
         end
         if (busy) busy_seen++;
`ifdef JERICALLA_ISSUE_STATS_EN
         if (cyc == 1) stall_c1 = stall_count;
`endif
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc   = cyc;
               pc_at_done = pc;
`ifdef JERICALLA_ISSUE_STATS_EN
               stall_done = stall_count;
`endif
            end
         end
         if (cyc == inj_cyc) begin
            start     = 1'b1;
            prog_len  = 1;
            prog_we   = 1'b1;
            prog_addr = 5'd1;
            prog_data = 17'h1ABCD;
         end
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({instr, instr_valid, pc, busy, done} !== '0) begin
         bad++;
         $display("FAIL reset_state got instr=%h v=%b pc=%0d busy=%b done=%b exp all zero",
                  instr, instr_valid, pc, busy, done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_independent();
      int w_cyc; logic [16:0] w, e;
      prog_q = '{{2'b00, 5'd4, 5'd0, 5'd1}, {2'b01, 5'd5, 5'd1, 5'd2}, {2'b10, 5'd6, 5'd2, 5'd3}};
      load_prog();
      ecyc = '{2, 3, 4};
      run(3, 0, 12, 1'b0, '0);
      total++;
      if (obs_q.size() != 3) begin bad++; $display("FAIL indep_count got=%0d exp=3", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0 && ecyc.size() > 0) begin
         w = obs_q.pop_front(); e = exp_q.pop_front(); w_cyc = obs_cyc.pop_front();
         total++;
         if (w !== e || w_cyc != ecyc[0]) begin
            bad++;
            $display("FAIL indep_issue got=%h@%0d exp=%h@%0d", w, w_cyc, e, ecyc[0]);
         end
         void'(ecyc.pop_front());
      end
      total++;
      if (done_cyc != 7 || done_cnt != 1 || bubble_nz != 0) begin
         bad++;
         $display("FAIL indep_done got cyc=%0d n=%0d nzb=%0d exp cyc=7 n=1 nzb=0", done_cyc, done_cnt, bubble_nz);
      end
      total++;
      if (pc_at_done !== 5'd3) begin bad++; $display("FAIL indep_pc got=%0d exp=3", pc_at_done); end
   endtask

   task automatic test_raw();
      int w_cyc; logic [16:0] w, e;
      prog_q = '{{2'b00, 5'd4, 5'd0, 5'd1}, {2'b11, 5'd31, 5'd7, 5'd4}};
      load_prog();
      ecyc = '{2, 5};
      run(2, 0, 12, 1'b0, '0);
      total++;
      if (obs_q.size() != 2) begin bad++; $display("FAIL raw_count got=%0d exp=2", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0 && ecyc.size() > 0) begin
         w = obs_q.pop_front(); e = exp_q.pop_front(); w_cyc = obs_cyc.pop_front();
         total++;
         if (w !== e || w_cyc != ecyc[0]) begin
            bad++;
            $display("FAIL raw_issue got=%h@%0d exp=%h@%0d", w, w_cyc, e, ecyc[0]);
         end
         void'(ecyc.pop_front());
      end
      total++;
      if (done_cyc != 8 || bubble_nz != 0) begin
         bad++;
         $display("FAIL raw_done got cyc=%0d nzb=%0d exp cyc=8 nzb=0", done_cyc, bubble_nz);
      end
`ifdef JERICALLA_ISSUE_STATS_EN
      total++;
      if (stall_done !== 16'd2) begin bad++; $display("FAIL stats_at_done got=%0d exp=2", stall_done); end
      exp_q.delete();
      run(1, 0, 6, 1'b0, '0);
      total++;
      if (stall_c1 !== 16'd0) begin bad++; $display("FAIL stats_cleared got=%0d exp=0", stall_c1); end
`endif
   endtask

   task automatic test_raw_dist2();
      int w_cyc; logic [16:0] w, e;
      prog_q = '{{2'b00, 5'd4, 5'd0, 5'd1}, {2'b00, 5'd5, 5'd0, 5'd1}, {2'b01, 5'd6, 5'd4, 5'd0}};
      load_prog();
      ecyc = '{2, 3, 5};
      run(3, 0, 12, 1'b0, '0);
      total++;
      if (obs_q.size() != 3) begin bad++; $display("FAIL dist2_count got=%0d exp=3", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0 && ecyc.size() > 0) begin
         w = obs_q.pop_front(); e = exp_q.pop_front(); w_cyc = obs_cyc.pop_front();
         total++;
         if (w !== e || w_cyc != ecyc[0]) begin
            bad++;
            $display("FAIL dist2_issue got=%h@%0d exp=%h@%0d", w, w_cyc, e, ecyc[0]);
         end
         void'(ecyc.pop_front());
      end
   endtask

   task automatic test_reg0();
      int w_cyc; logic [16:0] w, e;
      prog_q = '{{2'b00, 5'd0, 5'd1, 5'd2}, {2'b00, 5'd3, 5'd0, 5'd0}};
      load_prog();
      ecyc = '{2, 5};
      run(2, 0, 12, 1'b0, '0);
      total++;
      if (obs_q.size() != 2) begin bad++; $display("FAIL reg0_count got=%0d exp=2", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0 && ecyc.size() > 0) begin
         w = obs_q.pop_front(); e = exp_q.pop_front(); w_cyc = obs_cyc.pop_front();
         total++;
         if (w !== e || w_cyc != ecyc[0]) begin
            bad++;
            $display("FAIL reg0_issue got=%h@%0d exp=%h@%0d", w, w_cyc, e, ecyc[0]);
         end
         void'(ecyc.pop_front());
      end
   endtask

   task automatic test_store_no_write();
      int w_cyc; logic [16:0] w, e;
      prog_q = '{{2'b11, 5'd31, 5'd4, 5'd5}, {2'b00, 5'd6, 5'd31, 5'd31}};
      load_prog();
      ecyc = '{2, 3};
      run(2, 0, 10, 1'b0, '0);
      total++;
      if (obs_q.size() != 2) begin bad++; $display("FAIL sw_count got=%0d exp=2", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0 && ecyc.size() > 0) begin
         w = obs_q.pop_front(); e = exp_q.pop_front(); w_cyc = obs_cyc.pop_front();
         total++;
         if (w !== e || w_cyc != ecyc[0]) begin
            bad++;
            $display("FAIL sw_issue got=%h@%0d exp=%h@%0d", w, w_cyc, e, ecyc[0]);
         end
         void'(ecyc.pop_front());
      end
      total++;
      if (done_cyc != 6) begin bad++; $display("FAIL sw_done got=%0d exp=6", done_cyc); end
   endtask

   task automatic test_full_len();
      int w_cyc; int n; logic [16:0] w, e;
      prog_q.delete();
      ecyc.delete();
      for (int i = 0; i < 32; i++) begin
         prog_q.push_back({2'b11, i[4:0], 5'(31 - i), i[4:0]});
         ecyc.push_back(i + 2);
      end
      load_prog();
      run(32, 0, 42, 1'b0, '0);
      total++;
      if (obs_q.size() != 32) begin bad++; $display("FAIL full_count got=%0d exp=32", obs_q.size()); end
      n = 0;
      while (obs_q.size() > 0 && exp_q.size() > 0 && ecyc.size() > 0) begin
         w = obs_q.pop_front(); e = exp_q.pop_front(); w_cyc = obs_cyc.pop_front();
         if (w !== e || w_cyc != ecyc[0]) begin
            n++;
            $display("FAIL full_issue got=%h@%0d exp=%h@%0d", w, w_cyc, e, ecyc[0]);
         end
         void'(ecyc.pop_front());
      end
      total++;
      if (n != 0) bad++;
      total++;
      if (done_cyc != 36 || done_cnt != 1 || pc_at_done !== 5'd0) begin
         bad++;
         $display("FAIL full_done got cyc=%0d n=%0d pc=%0d exp cyc=36 n=1 pc=0", done_cyc, done_cnt, pc_at_done);
      end
   endtask

   task automatic test_cmd_busy();
      int w_cyc; logic [16:0] w, e;
      prog_q = '{{2'b00, 5'd4, 5'd0, 5'd1}, {2'b01, 5'd5, 5'd1, 5'd2}, {2'b10, 5'd6, 5'd2, 5'd3}};
      load_prog();
      run(3, 2, 14, 1'b0, '0);
      total++;
      if (obs_q.size() != 3 || done_cyc != 7 || done_cnt != 1) begin
         bad++;
         $display("FAIL busy_start got n=%0d done=%0d dn=%0d exp n=3 done=7 dn=1", obs_q.size(), done_cyc, done_cnt);
      end
      exp_q = prog_q;
      ecyc = '{2, 3, 4};
      run(3, 0, 10, 1'b0, '0);
      total++;
      if (obs_q.size() != 3) begin bad++; $display("FAIL busy_we_count got=%0d exp=3", obs_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0 && ecyc.size() > 0) begin
         w = obs_q.pop_front(); e = exp_q.pop_front(); w_cyc = obs_cyc.pop_front();
         total++;
         if (w !== e || w_cyc != ecyc[0]) begin
            bad++;
            $display("FAIL busy_we_issue got=%h@%0d exp=%h@%0d", w, w_cyc, e, ecyc[0]);
         end
         void'(ecyc.pop_front());
      end
   endtask

   task automatic test_len_zero();
      run(0, 0, 6, 1'b0, '0);
      total++;
      if (done_cnt != 1 || done_cyc != 1 || busy_seen != 0 || obs_q.size() != 0) begin
         bad++;
         $display("FAIL len0 got dn=%0d done=%0d busy=%0d n=%0d exp dn=1 done=1 busy=0 n=0",
                  done_cnt, done_cyc, busy_seen, obs_q.size());
      end
   endtask

   task automatic test_we_start();
      logic [16:0] nw;
      nw = {2'b01, 5'd9, 5'd10, 5'd11};
      run(1, 0, 8, 1'b1, nw);
      total++;
      if (obs_q.size() != 1 || obs_q[0] !== nw || obs_cyc[0] != 2 || done_cyc != 5) begin
         bad++;
         $display("FAIL we_start got n=%0d w=%h done=%0d exp n=1 w=%h done=5",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'd0, done_cyc, nw);
      end
   endtask

   task automatic test_reset_run();
      int stray;
      prog_q = '{{2'b00, 5'd4, 5'd0, 5'd1}, {2'b01, 5'd5, 5'd1, 5'd2}, {2'b10, 5'd6, 5'd2, 5'd3}};
      load_prog();
      @(negedge clk); start = 1'b1; prog_len = 6'd3;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || instr_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_run_pre got busy=%b v=%b exp busy=1 v=1", busy, instr_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({instr, instr_valid, pc, busy, done} !== '0) begin
         bad++;
         $display("FAIL rst_run_clear got instr=%h v=%b pc=%0d busy=%b done=%b exp all zero",
                  instr, instr_valid, pc, busy, done);
      end
      stray = 0;
      repeat (3) begin @(negedge clk); if (done || busy || instr_valid) stray++; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); if (done || busy || instr_valid) stray++; end
      total++;
      if (stray != 0) begin bad++; $display("FAIL rst_run_after got=%0d exp=0", stray); end
   endtask

   initial begin
      test_reset();
      test_independent();
      test_raw();
      test_raw_dist2();
      test_reg0();
      test_store_no_write();
      test_full_len();
      test_cmd_busy();
      test_len_zero();
      test_we_start();
      test_reset_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
